max_diff_controller: RTL and testbench

- Control FSM for the max/min-difference datapath; sits directly upstream of it.
- Sequences the datapath's register load and clear strobes over the address range start_addr..end_addr.
- Issues one memory read per address and consumes the datapath status flags i_lte_j, data_lt_min and data_lt_max.
- Handles the go/done/busy handshake with the host and flags a memory-read timeout.

---
 rtl/max_diff_controller_if.sv | 58 +++++
 rtl/max_diff_controller.sv | 201 ++++++++++++++++++++
 tb/tb_max_diff_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/max_diff_controller_if.sv
// rtl/max_diff_controller_if.sv - host, memory and datapath signal bundle for max_diff_controller
interface max_diff_controller_if #(
  parameter int ADDR_WIDTH = 8
);
  // host handshake
  logic                  go;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  busy;
  logic                  done;
  logic                  error;

  // memory read port
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_valid;

  // datapath status flags
  logic                  i_lte_j;
  logic                  data_lt_min;
  logic                  data_lt_max;

  // datapath controls
  logic                  i_sel;
  logic                  i_ld;
  logic                  i_clr;
  logic                  j_ld;
  logic                  j_clr;
  logic                  data_reg_ld;
  logic                  data_reg_clr;
  logic                  sel_def_max_min;
  logic                  min_ld;
  logic                  min_clr;
  logic                  max_ld;
  logic                  max_clr;
  logic                  max_diff_ld;
  logic                  max_diff_clr;

  // controller side
  modport master (
    input  go, start_addr, end_addr, mem_rd_valid,
    input  i_lte_j, data_lt_min, data_lt_max,
    output busy, done, error, mem_rd_en, mem_addr,
    output i_sel, i_ld, i_clr, j_ld, j_clr, data_reg_ld, data_reg_clr,
    output sel_def_max_min, min_ld, min_clr, max_ld, max_clr,
    output max_diff_ld, max_diff_clr
  );

  // host / memory / datapath side
  modport slave (
    output go, start_addr, end_addr, mem_rd_valid,
    output i_lte_j, data_lt_min, data_lt_max,
    input  busy, done, error, mem_rd_en, mem_addr,
    input  i_sel, i_ld, i_clr, j_ld, j_clr, data_reg_ld, data_reg_clr,
    input  sel_def_max_min, min_ld, min_clr, max_ld, max_clr,
    input  max_diff_ld, max_diff_clr
  );
endinterface

// File: rtl/max_diff_controller.sv
// rtl/max_diff_controller.sv - control FSM sequencing the max/min-difference datapath over an address range
module max_diff_controller #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  max_diff_controller_if.master bus
);

  localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_RD_REQ,
    S_RD_WAIT,
    S_CMP,
    S_DIFF,
    S_EMPTY,
    S_ERR,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [TW-1:0]         r_tmo;
  logic                  r_err;

  // Leaving on end-equality (not on i>j) keeps the counter from wrapping past 0xFF.
  logic w_last;
  assign w_last = (r_addr == r_end);

  logic                  w_mem_rd_en;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_i_sel;
  logic                  w_i_ld;
  logic                  w_j_ld;
  logic                  w_data_reg_ld;
  logic                  w_data_reg_clr;
  logic                  w_sel_def_max_min;
  logic                  w_min_ld;
  logic                  w_max_ld;
  logic                  w_max_diff_ld;
  logic                  w_max_diff_clr;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_error;

  // State sequencing plus address, saved-end and timeout bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_end   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (bus.go) begin
            r_addr  <= bus.start_addr;
            r_end   <= bus.end_addr;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_state <= bus.i_lte_j ? S_RD_REQ : S_EMPTY;
        end
        S_RD_REQ: begin
          r_tmo   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bus.mem_rd_valid) begin
            r_state <= S_CMP;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= S_ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CMP: begin
          if (w_last) begin
            r_state <= S_DIFF;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_DIFF: begin
          r_state <= S_DONE;
        end
        S_EMPTY: begin
          r_state <= S_DONE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath strobes decoded from state; only the CMP min/max loads and the RD_WAIT data load follow live inputs
  always_comb begin
    w_mem_rd_en       = 1'b0;
    w_mem_addr        = '0;
    w_i_sel           = 1'b0;
    w_i_ld            = 1'b0;
    w_j_ld            = 1'b0;
    w_data_reg_ld     = 1'b0;
    w_data_reg_clr    = 1'b0;
    w_sel_def_max_min = 1'b0;
    w_min_ld          = 1'b0;
    w_max_ld          = 1'b0;
    w_max_diff_ld     = 1'b0;
    w_max_diff_clr    = 1'b0;
    w_busy            = (r_state != S_IDLE);
    w_done            = 1'b0;
    w_error           = 1'b0;
    case (r_state)
      S_INIT: begin
        // i <- start, j <- end, min <- 0xFF, max <- 0x00
        w_i_ld         = 1'b1;
        w_j_ld         = 1'b1;
        w_min_ld       = 1'b1;
        w_max_ld       = 1'b1;
        w_data_reg_clr = 1'b1;
        w_max_diff_clr = 1'b1;
      end
      S_RD_REQ: begin
        w_mem_rd_en = 1'b1;
        w_mem_addr  = r_addr;
      end
      S_RD_WAIT: begin
        // memory data is wired straight into the data register
        w_data_reg_ld = bus.mem_rd_valid;
      end
      S_CMP: begin
        w_sel_def_max_min = 1'b1;
        w_min_ld          = bus.data_lt_min;
        w_max_ld          = bus.data_lt_max;
        if (!w_last) begin
          w_i_sel = 1'b1;
          w_i_ld  = 1'b1;
        end
      end
      S_DIFF: begin
        w_max_diff_ld = 1'b1;
      end
      S_EMPTY: begin
        // avoid publishing 0x00 - 0xFF when nothing was read
        w_max_diff_clr = 1'b1;
      end
      S_ERR: begin
        w_max_diff_clr = 1'b1;
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_error = r_err;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_rd_en       = w_mem_rd_en;
  assign bus.mem_addr        = w_mem_addr;
  assign bus.i_sel           = w_i_sel;
  assign bus.i_ld            = w_i_ld;
  assign bus.i_clr           = 1'b0;
  assign bus.j_ld            = w_j_ld;
  assign bus.j_clr           = 1'b0;
  assign bus.data_reg_ld     = w_data_reg_ld;
  assign bus.data_reg_clr    = w_data_reg_clr;
  assign bus.sel_def_max_min = w_sel_def_max_min;
  assign bus.min_ld          = w_min_ld;
  assign bus.min_clr         = 1'b0;
  assign bus.max_ld          = w_max_ld;
  assign bus.max_clr         = 1'b0;
  assign bus.max_diff_ld     = w_max_diff_ld;
  assign bus.max_diff_clr    = w_max_diff_clr;
  assign bus.busy            = w_busy;
  assign bus.done            = w_done;
  assign bus.error           = w_error;

endmodule

// File: tb/tb_max_diff_controller.sv
// tb/tb_max_diff_controller.sv - randomized self-checking bench for max_diff_controller
module tb_max_diff_controller;

  localparam int AW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  max_diff_controller_if #(.ADDR_WIDTH(AW)) ifc();

  max_diff_controller #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [7:0] mem [256];
  logic [7:0] mem_data;
  int         dly_q[$];
  int         rd_log[$];
  bit         pend;
  int         cnt;
  logic [7:0] paddr;

  always @(negedge clk) begin
    ifc.mem_rd_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          ifc.mem_rd_valid = 1'b1;
          mem_data = mem[paddr];
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (ifc.mem_rd_en) begin
        rd_log.push_back(int'(ifc.mem_addr));
        paddr = ifc.mem_addr;
        pend = 1'b1;
        if (dly_q.size() > 0) cnt = dly_q.pop_front();
        else cnt = 0;
      end
    end
  end

  // ---------------- downstream datapath stand-in ----------------
  logic [7:0] dp_i, dp_j, dp_data, dp_min, dp_max, dp_diff;

  always @(posedge clk) begin
    if (rst) begin
      dp_i <= 8'h00; dp_j <= 8'h00; dp_data <= 8'h00;
      dp_min <= 8'h00; dp_max <= 8'h00; dp_diff <= 8'h00;
    end else begin
      if (ifc.i_clr) dp_i <= 8'h00;
      else if (ifc.i_ld) dp_i <= ifc.i_sel ? dp_i + 8'd1 : ifc.start_addr;
      if (ifc.j_clr) dp_j <= 8'h00;
      else if (ifc.j_ld) dp_j <= ifc.end_addr;
      if (ifc.data_reg_clr) dp_data <= 8'h00;
      else if (ifc.data_reg_ld) dp_data <= mem_data;
      if (ifc.min_clr) dp_min <= 8'h00;
      else if (ifc.min_ld) dp_min <= ifc.sel_def_max_min ? dp_data : 8'hFF;
      if (ifc.max_clr) dp_max <= 8'h00;
      else if (ifc.max_ld) dp_max <= ifc.sel_def_max_min ? dp_data : 8'h00;
      if (ifc.max_diff_clr) dp_diff <= 8'h00;
      else if (ifc.max_diff_ld) dp_diff <= dp_max - dp_min;
    end
  end

  assign ifc.i_lte_j     = (dp_i <= dp_j);
  assign ifc.data_lt_min = (dp_data < dp_min);
  assign ifc.data_lt_max = (dp_max < dp_data);

  logic [25:0] outs;
  assign outs = {ifc.mem_rd_en, ifc.mem_addr, ifc.i_sel, ifc.i_ld, ifc.i_clr, ifc.j_ld, ifc.j_clr,
                 ifc.data_reg_ld, ifc.data_reg_clr, ifc.sel_def_max_min, ifc.min_ld, ifc.min_clr,
                 ifc.max_ld, ifc.max_clr, ifc.max_diff_ld, ifc.max_diff_clr,
                 ifc.busy, ifc.done, ifc.error};

  // ---------------- one scan against the reference ----------------
  // tmo_at: index of element whose read never completes (-1 for none)
  task automatic run_scan(input string tag, input logic [7:0] s, input logic [7:0] e,
                          input int tmo_at, input bit zero_wait, input bit noise);
    int exp_addr[$];
    int exp_cyc, exp_diff, exp_err, n, cyc, busy_low, mism, lo, hi, d, v;
    bit seen;
    rd_log.delete();
    dly_q.delete();
    exp_err = 0;
    exp_diff = 0;
    if (s > e) begin
      exp_cyc = 4;
    end else begin
      n = int'(e) - int'(s) + 1;
      exp_cyc = 1;
      lo = 255;
      hi = 0;
      for (int k = 0; k < n; k++) begin
        if (k == tmo_at) d = TMO;
        else if (zero_wait) d = 0;
        else if ($urandom_range(0, 9) == 0) d = TMO - 1;
        else d = $urandom_range(0, 3);
        dly_q.push_back(d);
        exp_addr.push_back(int'(s) + k);
        if (d >= TMO) begin
          exp_err = 1;
          exp_cyc += 2 + TMO + 2;
          break;
        end
        exp_cyc += 4 + d;
        v = int'(mem[int'(s) + k]);
        if (v < lo) lo = v;
        if (v > hi) hi = v;
      end
      if (exp_err == 0) begin
        exp_cyc += 2;
        exp_diff = hi - lo;
      end
    end

    ifc.start_addr = s;
    ifc.end_addr   = e;
    ifc.go         = 1'b1;
    cyc = 0;
    seen = 1'b0;
    busy_low = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      ifc.go = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
      if (!ifc.busy) busy_low++;
    end
    ifc.go = 1'b0;

    check({tag, "/done_cycle"}, seen ? cyc : -1, exp_cyc);
    check({tag, "/error"}, ifc.error, exp_err);
    check({tag, "/max_diff"}, dp_diff, exp_diff);
    check({tag, "/busy_gaps"}, busy_low, 0);
    @(negedge clk);
    check({tag, "/idle_after"}, {ifc.busy, ifc.done, ifc.error, ifc.mem_rd_en}, 0);
    check({tag, "/n_reads"}, rd_log.size(), exp_addr.size());
    mism = 0;
    for (int k = 0; k < exp_addr.size() && k < rd_log.size(); k++)
      if (rd_log[k] != exp_addr[k]) mism++;
    check({tag, "/read_addrs"}, mism, 0);
  endtask

  initial begin
    int s, e, len, tmo;
    int n_done, n_rd;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    ifc.go = 1'b0;
    ifc.start_addr = '0;
    ifc.end_addr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 0);
    rst = 1'b0;
    @(negedge clk);

    mem[8'h10] = 8'd5; mem[8'h11] = 8'd2; mem[8'h12] = 8'd9; mem[8'h13] = 8'd7;
    run_scan("basic", 8'h10, 8'h13, -1, 1'b1, 1'b0);

    mem[8'h40] = 8'h40;
    run_scan("single", 8'h40, 8'h40, -1, 1'b1, 1'b0);

    run_scan("empty", 8'h20, 8'h1F, -1, 1'b1, 1'b0);

    mem[8'hFE] = 8'h03; mem[8'hFF] = 8'hF0;
    run_scan("top_no_wrap", 8'hFE, 8'hFF, -1, 1'b1, 1'b0);

    run_scan("timeout", 8'h10, 8'h13, 0, 1'b1, 1'b0);
    run_scan("after_timeout", 8'h10, 8'h13, -1, 1'b1, 1'b0);
    run_scan("busy_go", 8'h10, 8'h13, -1, 1'b1, 1'b1);

    // reset while waiting on a slow read
    rd_log.delete();
    dly_q.delete();
    repeat (4) dly_q.push_back(8);
    ifc.start_addr = 8'h10;
    ifc.end_addr = 8'h13;
    ifc.go = 1'b1;
    @(negedge clk);
    ifc.go = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", outs, 0);
    n_done = 0;
    n_rd = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.done) n_done++;
      if (ifc.mem_rd_en) n_rd++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_no_reads", n_rd, 0);
    run_scan("after_reset", 8'h10, 8'h13, -1, 1'b1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      s = $urandom_range(0, 255);
      len = $urandom_range(0, 6);
      if (len == 0) e = (s == 0) ? 0 : $urandom_range(0, s - 1);
      else e = (s + len - 1 > 255) ? 255 : s + len - 1;
      tmo = -1;
      if (len > 0 && $urandom_range(0, 6) == 0) tmo = $urandom_range(0, len - 1);
      run_scan($sformatf("rand%0d", r), 8'(s), 8'(e), tmo, 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
